// File: rtl/pattern_sequencer.sv
// Frame-locked pattern selector and pixel-coordinate generator for the VGA output chain.
// Optional build macro PATSEQ_SKIP_MASK_EN adds a SKIP_MASK port that excludes patterns.
module pattern_sequencer #(
    parameter int unsigned NUM_PAT       = 4,
    parameter int unsigned PAT_W         = 2,
    parameter int unsigned CNT_W         = 10,
    parameter bit          VS_ACTIVE_LOW = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               VS_IN,
    input  logic               DE_IN,
    input  logic               BTN_NEXT,
    input  logic               AUTO_EN,
    input  logic [7:0]         HOLD_FRAMES,
`ifdef PATSEQ_SKIP_MASK_EN
    input  logic [NUM_PAT-1:0] SKIP_MASK,
`endif
    output logic [PAT_W-1:0]   PAT_SEL,
    output logic               PAT_CHANGE,
    output logic [CNT_W-1:0]   HPOS,
    output logic [CNT_W-1:0]   VPOS,
    output logic               DE_OUT,
    output logic               LOCKED,
    output logic [15:0]        FRAME_CNT
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [0:0] {StManual, StAuto} state_e;

    state_e           state_q;
    logic             vs_q, de_q, btn_q, fb_q;
    logic             de_out_q, locked_q, pending_q, pat_change_q;
    logic [CNT_W-1:0] hpos_q, vpos_q;
    logic [15:0]      frame_cnt_q;
    logic [PAT_W-1:0] pat_sel_q, next_pat;
    logic [7:0]       hold_q, hold_init;
    logic             vs_edge, btn_rise, force_adv, do_adv;

    assign vs_edge   = VS_ACTIVE_LOW ? (vs_q & ~VS_IN) : (~vs_q & VS_IN);
    assign btn_rise  = BTN_NEXT & ~btn_q;
    assign hold_init = (HOLD_FRAMES == 8'd0) ? 8'd0 : HOLD_FRAMES - 8'd1;

`ifdef PATSEQ_SKIP_MASK_EN
    int unsigned cand;
    logic        found;

    // First unmasked index after the current one, in wrap order.
    always_comb begin
        next_pat = pat_sel_q;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned k = 1; k < NUM_PAT; k++) begin
            cand = 32'(pat_sel_q) + k;
            if (cand >= NUM_PAT) begin
                cand = cand - NUM_PAT;
            end
            if (!found && !SKIP_MASK[cand[PAT_W-1:0]]) begin
                next_pat = cand[PAT_W-1:0];
                found    = 1'b1;
            end
        end
    end

    assign force_adv = SKIP_MASK[pat_sel_q];
`else
    assign next_pat  = (pat_sel_q == PAT_W'(NUM_PAT - 1)) ? '0 : pat_sel_q + PAT_W'(1);
    assign force_adv = 1'b0;
`endif

    // A press and an expiring hold counter still give a single advance.
    always_comb begin
        do_adv = pending_q | force_adv;
        if (state_q == StAuto && AUTO_EN && hold_q == 8'd0) begin
            do_adv = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vs_q        <= VS_IN;
            de_q        <= DE_IN;
            btn_q       <= BTN_NEXT;
            fb_q        <= 1'b0;
            de_out_q    <= 1'b0;
            hpos_q      <= '0;
            vpos_q      <= '0;
            locked_q    <= 1'b0;
            frame_cnt_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            vs_q     <= VS_IN;
            de_q     <= DE_IN;
            btn_q    <= BTN_NEXT;
            fb_q     <= vs_edge;
            de_out_q <= DE_IN;

            if (!locked_q || !DE_IN || !de_q) begin
                hpos_q <= '0;
            end else if (hpos_q != CntMax) begin
                hpos_q <= hpos_q + CNT_W'(1);
            end

            if (fb_q || !locked_q) begin
                vpos_q <= '0;
            end else if (de_q && !DE_IN && vpos_q != CntMax) begin
                vpos_q <= vpos_q + CNT_W'(1);
            end

            // A press landing on the boundary cycle is carried to the next frame.
            if (fb_q) begin
                locked_q    <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                pending_q   <= btn_rise;
            end else if (btn_rise) begin
                pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StManual;
            hold_q       <= 8'd0;
            pat_sel_q    <= '0;
            pat_change_q <= 1'b0;
        end else begin
            pat_change_q <= 1'b0;
            if (fb_q) begin
                if (do_adv) begin
                    pat_sel_q    <= next_pat;
                    pat_change_q <= (next_pat != pat_sel_q);
                end
                case (state_q)
                    StManual: begin
                        if (AUTO_EN) begin
                            state_q <= StAuto;
                            hold_q  <= hold_init;
                        end
                    end
                    StAuto: begin
                        if (!AUTO_EN) begin
                            state_q <= StManual;
                        end else if (do_adv) begin
                            hold_q <= hold_init;
                        end else begin
                            hold_q <= hold_q - 8'd1;
                        end
                    end
                    default: state_q <= StManual;
                endcase
            end
        end
    end

    assign PAT_SEL    = pat_sel_q;
    assign PAT_CHANGE = pat_change_q;
    assign HPOS       = hpos_q;
    assign VPOS       = vpos_q;
    assign DE_OUT     = de_out_q;
    assign LOCKED     = locked_q;
    assign FRAME_CNT  = frame_cnt_q;

endmodule
